// File: rtl/fmap_pkg.sv
// fmap_pkg: shared types and defaults for the feature-map collector.
// Holds the FSM state enum, default geometry, frame depth and ReLU helper.
package fmap_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FULL
  } state_t;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_FMAP_W     = 24;
  localparam int DEF_FMAP_H     = 24;
  localparam int DEF_DEPTH      = DEF_FMAP_W * DEF_FMAP_H;

  // A ReLU zeroes any word whose sign bit is set.
  function automatic logic relu_zero(input logic msb);
    return msb;
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// fmap_ram: simple dual-port synchronous RAM, read-first, 1-cycle read.
// Ports: clk_i; write we_i/waddr_i/wdata_i; read re_i/raddr_i -> rdata_o.
module fmap_ram #(
  parameter int DW    = 24,
  parameter int AW    = 10,
  parameter int DEPTH = 576
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Non-blocking read of mem gives the pre-write value on a collision.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_collector.sv
// fmap_collector: stores one raster-order feature map, then serves reads.
// In: clk, rst(async low), start, data_in/valid_in, rd_en/rd_addr.
// Out: rd_data/rd_valid, busy, frame_done, full, overflow.
// FMAP_COLLECTOR_RELU_EN: when defined, negative pixels are stored as 0.
module fmap_collector
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FMAP_W     = DEF_FMAP_W,
  parameter int FMAP_H     = DEF_FMAP_H,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  full,
  output logic                  overflow
);

  localparam int DEPTH = FMAP_W * FMAP_H;
  localparam int CW = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
  localparam int RW = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state_q;
  logic [CW-1:0]           col_q, col_b, col_d;
  logic [RW-1:0]           row_q, row_b, row_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_b, addr_d;
  logic                    busy_q, full_q, fd_q, ovf_q;
  logic                    rv_q, oor_q;
  logic                    run, we, wr_last, in_rng;
  logic [DATA_WIDTH-1:0]   wdata, ram_q;

  // start rebases the counters this cycle so a same-cycle pixel lands at 0.
  always_comb begin
    run     = start || (state_q == S_COLLECT);
    we      = valid_in && run;
    col_b   = start ? '0 : col_q;
    row_b   = start ? '0 : row_q;
    addr_b  = start ? '0 : addr_q;
    wr_last = we && (col_b == COL_LAST) && (row_b == ROW_LAST);
    col_d   = col_b;
    row_d   = row_b;
    addr_d  = addr_b;
    if (we) begin
      addr_d = addr_b + 1'b1;
      if (col_b == COL_LAST) begin
        col_d = '0;
        row_d = row_b + 1'b1;
      end else begin
        col_d = col_b + 1'b1;
      end
    end
  end

`ifdef FMAP_COLLECTOR_RELU_EN
  assign wdata = relu_zero(data_in[DATA_WIDTH-1]) ? '0 : data_in;
`else
  assign wdata = data_in;
`endif

  assign in_rng = {1'b0, rd_addr} < DEPTH_X;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      fd_q  <= 1'b0;
      rv_q  <= rd_en;
      oor_q <= ~in_rng;
      if (start) begin
        ovf_q <= 1'b0;
      end else if (valid_in && state_q != S_COLLECT) begin
        ovf_q <= 1'b1;
      end
      if (wr_last) begin
        state_q <= S_FULL;
        busy_q  <= 1'b0;
        full_q  <= 1'b1;
        fd_q    <= 1'b1;
        col_q   <= '0;
        row_q   <= '0;
        addr_q  <= '0;
      end else if (run) begin
        state_q <= S_COLLECT;
        busy_q  <= 1'b1;
        full_q  <= 1'b0;
        col_q   <= col_d;
        row_q   <= row_d;
        addr_q  <= addr_d;
      end
    end
  end

  fmap_ram #(
    .DW   (DATA_WIDTH),
    .AW   (ADDR_WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (we),
    .waddr_i(addr_b),
    .wdata_i(wdata),
    .re_i   (rd_en && in_rng),
    .raddr_i(rd_addr),
    .rdata_o(ram_q)
  );

  assign rd_data    = (rv_q && !oor_q) ? ram_q : '0;
  assign rd_valid   = rv_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign full       = full_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_fmap_collector.sv
// tb_fmap_collector: directed self-checking bench for fmap_collector.
// Streams frames, probes reads, overflow, restart, reset and ReLU.
module tb_fmap_collector;

  localparam int DW = 24;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          valid_in = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, busy, frame_done, full, overflow;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  fmap_collector #(
    .DATA_WIDTH(DW),
    .FMAP_W    (24),
    .FMAP_H    (24),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .frame_done(frame_done),
    .full      (full),
    .overflow  (overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    valid_in = 1'b1;
    data_in  = v;
    tick();
    valid_in = 1'b0;
    if (frame_done) fd_cnt++;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a,
                    input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_v"}, 32'(rd_valid), 32'd1);
    chk(tag, 32'(rd_data), exp);
    tick();
    chk({tag, "_v0"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b1;
    tick();

    // overflow in IDLE, cleared by start
    push(24'h000055);
    chk("idle_ovf", 32'(overflow), 1);
    chk("idle_busy", 32'(busy), 0);
    pulse_start();
    chk("start_clr_ovf", 32'(overflow), 0);
    chk("start_busy", 32'(busy), 1);

    // full frame, back to back
    fd_cnt = 0;
    for (int i = 1; i <= 576; i++) begin
      push(DW'(i));
      if (i == 575) chk("f1_fd_early", 32'(frame_done), 0);
    end
    chk("f1_fd", 32'(frame_done), 1);
    chk("f1_full", 32'(full), 1);
    chk("f1_busy", 32'(busy), 0);
    tick();
    chk("f1_fd_pulse", 32'(frame_done), 0);
    chk("f1_full_hold", 32'(full), 1);
    chk("f1_fd_cnt", 32'(fd_cnt), 1);
    rd("f1_a0", 10'd0, 32'd1);
    rd("f1_a23", 10'd23, 32'd24);
    rd("f1_a24", 10'd24, 32'd25);
    rd("f1_a575", 10'd575, 32'd576);

    // overflow in FULL, contents unchanged
    push(24'h000055);
    chk("full_ovf", 32'(overflow), 1);
    tick();
    chk("full_ovf_sticky", 32'(overflow), 1);
    chk("full_stays", 32'(full), 1);
    rd("full_a0", 10'd0, 32'd1);
    rd("full_a575", 10'd575, 32'd576);
    pulse_start();
    chk("restart_clr_ovf", 32'(overflow), 0);
    chk("restart_full", 32'(full), 0);

    // gapped frame, values 2*i
    fd_cnt = 0;
    for (int i = 1; i <= 576; i++) begin
      push(DW'(2 * i));
      if (i == 576) chk("f2_fd", 32'(frame_done), 1);
      else tick();
    end
    chk("f2_fd_cnt", 32'(fd_cnt), 1);
    chk("f2_full", 32'(full), 1);
    rd("f2_a0", 10'd0, 32'd2);
    rd("f2_a300", 10'd300, 32'd602);
    rd("f2_a575", 10'd575, 32'd1152);

    // out-of-range reads
    rd("oor_576", 10'd576, 32'd0);
    rd("oor_1023", 10'd1023, 32'd0);

    // same-cycle read and write to address 5
    pulse_start();
    for (int i = 0; i < 5; i++) push(DW'(12'hA00 + i));
    valid_in = 1'b1;
    data_in  = 24'h000A05;
    rd_en    = 1'b1;
    rd_addr  = 10'd5;
    tick();
    valid_in = 1'b0;
    rd_en    = 1'b0;
    chk("rw_v", 32'(rd_valid), 1);
    chk("rw_old", 32'(rd_data), 32'd12);
    tick();
    rd("rw_new", 10'd5, 32'h0A05);

    // restart with a same-cycle pixel lands at address 0
    start    = 1'b1;
    valid_in = 1'b1;
    data_in  = 24'h000777;
    tick();
    start    = 1'b0;
    valid_in = 1'b0;
    chk("rs_busy", 32'(busy), 1);
    rd("rs_a0", 10'd0, 32'h0777);
    rd("rs_a6_old", 10'd6, 32'd14);

    // reset after 100 pixels of a frame
    for (int i = 1; i < 100; i++) push(DW'(i));
    rd_en   = 1'b1;
    rd_addr = 10'd1;
    tick();
    rd_en = 1'b0;
    chk("pre_rst_rv", 32'(rd_valid), 1);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rv", 32'(rd_valid), 0);
    chk("mid_rst_rd", 32'(rd_data), 0);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_fd", 32'(frame_done), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    tick();
    rst = 1'b1;
    tick();
    push(24'h000055);
    chk("post_rst_idle", 32'(overflow), 1);

    // full frame after reset
    pulse_start();
    chk("f3_ovf_clr", 32'(overflow), 0);
    fd_cnt = 0;
    for (int i = 1; i <= 576; i++) push(DW'(i + 256));
    chk("f3_fd", 32'(frame_done), 1);
    chk("f3_full", 32'(full), 1);
    chk("f3_fd_cnt", 32'(fd_cnt), 1);
    rd("f3_a0", 10'd0, 32'h101);
    rd("f3_a100", 10'd100, 32'h165);
    rd("f3_a575", 10'd575, 32'h340);

    // write-port ReLU
    pulse_start();
    push(24'hFFFFF0);
    push(24'h000010);
`ifdef FMAP_COLLECTOR_RELU_EN
    rd("relu_neg", 10'd0, 32'd0);
`else
    rd("relu_neg", 10'd0, 32'h00FFFFF0);
`endif
    rd("relu_pos", 10'd1, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
